// File: rtl/cpu0_io_responder_pkg.sv
// Shared definitions for the cpu0 console-output responder.
// Register map, bit positions, bus size codes and unpacker states.
package cpu0_io_responder_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_INT16 = 2'd1;
    localparam logic [1:0] SZ_INT24 = 2'd2;
    localparam logic [1:0] SZ_INT32 = 2'd3;

    localparam logic [1:0] OFF_DATA   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CTRL   = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam int ST_OVF   = 9;
    localparam int ST_FULL  = 8;
    localparam int ST_EMPTY = 7;
    localparam int ST_BUSY  = 6;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_OVF_CLR = 1;

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] UNPACK = 1'b1;

    function automatic logic [2:0] size_bytes(input logic [1:0] sz);
        logic [2:0] n;
        unique case (sz)
            SZ_BYTE:  n = 3'd1;
            SZ_INT16: n = 3'd2;
            SZ_INT24: n = 3'd3;
            default:  n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/cpu0_io_responder_if.sv
// cpu0 memory-bus strobe/data plus the character sink handshake.
// The responder is the slave; the CPU/sink side is the master.
interface cpu0_io_responder_if;

    logic        en;
    logic        rw;
    logic [1:0]  m_size;
    logic [31:0] abus;
    logic [31:0] dbus_in;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        irq;

    modport slave (
        input  en, rw, m_size, abus, dbus_in, tx_ready,
        output tx_valid, tx_data, irq
    );

    modport master (
        output en, rw, m_size, abus, dbus_in, tx_ready,
        input  tx_valid, tx_data, irq
    );

endinterface

// File: rtl/cpu0_sync_fifo.sv
// Single-clock FIFO with occupancy count.
// A push into a full FIFO is taken only when a pop frees the slot.
module cpu0_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // pointer and occupancy bookkeeping; pointers wrap naturally
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // storage array, no reset needed
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cpu0_io_responder.sv
// Memory-mapped console output for cpu0: DATA/STATUS/CTRL window,
// store unpacker feeding a TX FIFO, sticky overflow and empty irq.
module cpu0_io_responder
    import cpu0_io_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0008_0000,
    parameter int          FIFO_DEPTH = 16,
    parameter int          CNT_W      = 5
) (
    input  logic               clock,
    input  logic               reset,
    cpu0_io_responder_if.slave bus,
    output logic [31:0]        dbus_out
);

    logic             hit;
    logic             rd;
    logic             wr;
    logic [1:0]       off;
    logic             data_wr;
    logic             ctrl_wr;
    logic             unused_abus;

    logic [0:0]       state;
    logic [0:0]       state_nx;
    logic [31:0]      sh;
    logic [31:0]      sh_nx;
    logic [2:0]       left;
    logic [2:0]       left_nx;
    logic             busy;
    logic             load;

    logic             push;
    logic [7:0]       wbyte;
    logic             pop;
    logic             push_ok;
    logic [7:0]       head;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] cnt_nx;
    logic             full;
    logic             empty;

    logic             ovf;
    logic             ovf_set;
    logic             ovf_clr;
    logic             irq_en;
    logic             irq_en_nx;
    logic             irq_q;

    logic [31:0]      rmux;
    logic [31:0]      rdata;
    logic             rd_drive;

    assign hit = bus.en & (bus.abus[31:4] == BASE_ADDR[31:4]);
    assign rd  = hit & bus.rw;
    assign wr  = hit & ~bus.rw;
    assign off = bus.abus[3:2];
    assign unused_abus = ^bus.abus[1:0];

    assign data_wr = wr & (off == OFF_DATA);
    assign ctrl_wr = wr & (off == OFF_CTRL);

    assign busy = (state == UNPACK);
    assign load = data_wr & ~busy
                & (bus.m_size != SZ_BYTE)
                & (bus.dbus_in[7:0] != 8'h00);

    // unpacker: look ahead so the last non-zero byte ends UNPACK
    always_comb begin
        state_nx = state;
        sh_nx    = sh;
        left_nx  = left;
        unique case (state)
            IDLE: begin
                if (load) begin
                    state_nx = UNPACK;
                    sh_nx    = bus.dbus_in;
                    left_nx  = size_bytes(bus.m_size);
                end
            end
            UNPACK: begin
                if (left == 3'd1 || sh[15:8] == 8'h00) begin
                    state_nx = IDLE;
                end else begin
                    sh_nx   = {8'h00, sh[31:8]};
                    left_nx = left - 3'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // unpacker state registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            sh    <= '0;
            left  <= '0;
        end else begin
            state <= state_nx;
            sh    <= sh_nx;
            left  <= left_nx;
        end
    end

    assign push = busy
                | (data_wr & ~busy
                   & (bus.m_size == SZ_BYTE)
                   & (bus.dbus_in[7:0] != 8'h00));
    assign wbyte   = busy ? sh[7:0] : bus.dbus_in[7:0];
    assign pop     = ~empty & bus.tx_ready;
    assign push_ok = push & (~full | pop);
    assign cnt_nx  = count + CNT_W'(push_ok) - CNT_W'(pop);

    cpu0_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata (wbyte),
        .pop   (pop),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign bus.tx_valid = ~empty;
    assign bus.tx_data  = head;

    assign ovf_set   = (data_wr & busy) | (push & ~push_ok);
    assign ovf_clr   = ctrl_wr & bus.dbus_in[CTRL_OVF_CLR];
    assign irq_en_nx = ctrl_wr ? bus.dbus_in[CTRL_IRQ_EN] : irq_en;

    // sticky overflow (set beats clear) and interrupt enable
    always_ff @(posedge clock) begin
        if (!reset) begin
            ovf    <= 1'b0;
            irq_en <= 1'b0;
        end else begin
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
            irq_en <= irq_en_nx;
        end
    end

    // irq from next-state values so it tracks the FIFO with no lag
    always_ff @(posedge clock) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_en_nx
                   & (cnt_nx == '0)
                   & (state_nx == IDLE);
        end
    end

    assign bus.irq = irq_q;

    // read data selection from current register values
    always_comb begin
        rmux = '0;
        unique case (1'b1)
            (off == OFF_STATUS): begin
                rmux[ST_OVF]   = ovf;
                rmux[ST_FULL]  = full;
                rmux[ST_EMPTY] = empty;
                rmux[ST_BUSY]  = busy;
                rmux[5:0]      = 6'(count);
            end
            (off == OFF_CTRL): begin
                rmux[CTRL_IRQ_EN] = irq_en;
            end
            default: rmux = '0;
        endcase
    end

    // read data registered, bus driven only the cycle after the read
    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_drive <= 1'b0;
            rdata    <= '0;
        end else begin
            rd_drive <= rd;
            if (rd) rdata <= rmux;
        end
    end

    assign dbus_out = rd_drive ? rdata : 32'hzzzz_zzzz;

endmodule

// File: tb/tb_cpu0_io_responder.sv
// Bench for cpu0_io_responder: directed scenarios then random
// traffic, checked against a queue-based reference model.
module tb_cpu0_io_responder;

    import cpu0_io_responder_pkg::*;

    localparam logic [31:0] BASE  = 32'h0008_0000;
    localparam int          DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] dbus_out;

    cpu0_io_responder_if bus ();

    cpu0_io_responder #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (5)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .dbus_out (dbus_out)
    );

    always #5 clock = ~clock;

    logic [7:0]  mq [$];
    logic [7:0]  mp [$];
    bit          m_ovf;
    bit          m_irq_en;
    bit          m_rdv;
    logic [31:0] m_rdd;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s         = '0;
        s[9]      = m_ovf;
        s[8]      = (mq.size() == DEPTH);
        s[7]      = (mq.size() == 0);
        s[6]      = (mp.size() != 0);
        s[5:0]    = 6'(mq.size());
        return s;
    endfunction

    // reference behaviour of one clock edge
    task automatic model_edge();
        bit          hit;
        bit          wr;
        bit          rd;
        bit          busy0;
        bit          push;
        bit          set;
        bit          clr;
        logic [1:0]  off;
        logic [7:0]  b;
        logic [31:0] d;
        if (!reset) begin
            mq.delete();
            mp.delete();
            m_ovf    = 0;
            m_irq_en = 0;
            m_rdv    = 0;
            m_rdd    = '0;
            return;
        end
        hit   = bus.en && (bus.abus[31:4] == BASE[31:4]);
        wr    = hit && !bus.rw;
        rd    = hit && bus.rw;
        off   = bus.abus[3:2];
        d     = bus.dbus_in;
        m_rdv = rd;
        if (rd) begin
            if (off == 2'd1)      m_rdd = m_status();
            else if (off == 2'd2) m_rdd = {31'b0, m_irq_en};
            else                  m_rdd = '0;
        end
        busy0 = (mp.size() != 0);
        set   = 0;
        clr   = 0;
        push  = 0;
        b     = '0;
        if (mq.size() != 0 && bus.tx_ready) void'(mq.pop_front());
        if (busy0) begin
            b    = mp.pop_front();
            push = 1;
        end
        if (wr && off == 2'd0) begin
            if (busy0) begin
                set = 1;
            end else if (bus.m_size == SZ_BYTE) begin
                if (d[7:0] != 8'h00) begin
                    b    = d[7:0];
                    push = 1;
                end
            end else begin
                for (int i = 0; i < int'(bus.m_size) + 1; i++) begin
                    if (d[8*i +: 8] == 8'h00) break;
                    mp.push_back(d[8*i +: 8]);
                end
            end
        end
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(b);
            else                   set = 1;
        end
        if (wr && off == 2'd2) begin
            m_irq_en = d[0];
            clr      = d[1];
        end
        if (set)      m_ovf = 1;
        else if (clr) m_ovf = 0;
    endtask

    task automatic check_outputs();
        chk("tx_valid", 32'(bus.tx_valid), 32'(mq.size() != 0));
        if (mq.size() != 0)
            chk("tx_data", 32'(bus.tx_data), 32'(mq[0]));
        chk("irq", 32'(bus.irq),
            32'(m_irq_en && mq.size() == 0 && mp.size() == 0));
        chk("dbus_out", dbus_out,
            m_rdv ? m_rdd : 32'hzzzz_zzzz);
    endtask

    task automatic step(input bit e, input bit r,
                        input logic [1:0] sz,
                        input logic [31:0] a,
                        input logic [31:0] d,
                        input bit rdy, input bit rn);
        bus.en       = e;
        bus.rw       = r;
        bus.m_size   = sz;
        bus.abus     = a;
        bus.dbus_in  = d;
        bus.tx_ready = rdy;
        reset        = rn;
        @(posedge clock);
        model_edge();
        #1;
        check_outputs();
    endtask

    function automatic logic [31:0] ra(input logic [1:0] off);
        return {BASE[31:4], off, 2'($urandom_range(0, 3))};
    endfunction

    task automatic sb(input logic [7:0] c, input bit rdy);
        step(1, 0, SZ_BYTE, ra(2'd0), {24'($urandom), c}, rdy, 1);
    endtask

    task automatic stw(input logic [1:0] sz,
                       input logic [31:0] d, input bit rdy);
        step(1, 0, sz, ra(2'd0), d, rdy, 1);
    endtask

    task automatic ld(input logic [1:0] off, input bit rdy);
        step(1, 1, SZ_INT32, ra(off), $urandom, rdy, 1);
    endtask

    task automatic cw(input logic [31:0] d, input bit rdy);
        step(1, 0, SZ_INT32, ra(2'd2), d, rdy, 1);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++)
            step(0, 1'($urandom), 2'($urandom), $urandom,
                 $urandom, rdy, 1);
    endtask

    initial begin
        int          op;
        logic [31:0] d;
        bit          rdy;

        step(0, 0, 2'd0, '0, '0, 0, 0);
        step(0, 0, 2'd0, '0, '0, 0, 0);
        ld(OFF_STATUS, 0);
        chk("rst_status", dbus_out, 32'h0000_0080);

        cw(32'h1, 1);
        sb(8'h41, 1);
        chk("sb_data", 32'(bus.tx_data), 32'h41);
        chk("sb_irq_low", 32'(bus.irq), 32'h0);
        idle(1, 1);
        chk("sb_irq_high", 32'(bus.irq), 32'h1);
        idle(1, 1);

        stw(SZ_INT32, 32'h0043_4241, 1);
        ld(OFF_STATUS, 1);
        chk("st_busy", dbus_out, 32'h0000_00c0);
        idle(6, 1);

        for (int i = 0; i < 17; i++) sb(8'h50 + 8'(i), 0);
        ld(OFF_STATUS, 0);
        chk("ovf_full", dbus_out, 32'h0000_0310);
        cw(32'h3, 0);
        ld(OFF_STATUS, 0);
        chk("ovf_clr", dbus_out, 32'h0000_0110);

        sb(8'h70, 1);
        ld(OFF_STATUS, 0);
        chk("push_pop_full", dbus_out, 32'h0000_0110);
        idle(20, 1);

        stw(SZ_INT32, 32'h4443_4241, 1);
        sb(8'h55, 1);
        ld(OFF_STATUS, 1);
        chk("busy_discard", dbus_out, 32'h0000_0241);
        idle(6, 1);
        cw(32'h3, 1);

        stw(SZ_INT32, 32'h4443_4241, 0);
        ld(OFF_STATUS, 0);
        step(0, 0, 2'd0, '0, '0, 0, 0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        idle(2, 0);
        ld(OFF_STATUS, 0);
        chk("rst_mid_status", dbus_out, 32'h0000_0080);

        cw(32'h1, 1);
        for (int n = 0; n < 800; n++) begin
            op  = int'($urandom_range(0, 9));
            rdy = ($urandom_range(0, 3) != 0);
            d   = $urandom;
            if ($urandom_range(0, 3) == 0) d[7:0] = 8'h00;
            if ($urandom_range(0, 3) == 0) d[23:16] = 8'h00;
            if ($urandom_range(0, 299) == 0) begin
                step(0, 0, 2'd0, '0, '0, rdy, 0);
            end else begin
                unique case (op)
                    3, 4: sb(d[7:0], rdy);
                    5, 6: stw(2'($urandom_range(1, 3)), d, rdy);
                    7: ld(2'($urandom), rdy);
                    8: cw({30'b0, 2'($urandom_range(0, 3))}, rdy);
                    9: step(1, 1'($urandom), 2'($urandom),
                            {BASE[31:4] + 28'd1, 4'($urandom)},
                            d, rdy, 1);
                    default: idle(1, rdy);
                endcase
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
